// File: rtl/hazard_scoreboard.sv
// Multi-lane RAW hazard scoreboard: tracks in-flight writers after ID,
// selects the youngest producer per source operand and raises load-use stalls.
module hazard_scoreboard #(
  parameter int LANES    = 2,
  parameter int STAGES   = 3,
  parameter int REG_AW   = 5,
  parameter int DATA_W   = 32,
  parameter int LOAD_LAT = 1
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            FREEZE,
  input  logic                            FLUSH,
  input  logic [LANES-1:0]                issue_valid,
  input  logic [LANES-1:0]                issue_wen,
  input  logic [LANES-1:0]                issue_isload,
  input  logic [LANES*REG_AW-1:0]         issue_wreg,
  input  logic [LANES*REG_AW-1:0]         issue_srcA,
  input  logic [LANES*REG_AW-1:0]         issue_srcB,
  input  logic [STAGES*LANES*DATA_W-1:0]  stage_data,
  output logic                            stall,
  output logic [LANES-1:0]                fwdA_hit,
  output logic [LANES-1:0]                fwdB_hit,
  output logic [LANES*DATA_W-1:0]         fwdA_data,
  output logic [LANES*DATA_W-1:0]         fwdB_data,
  output logic [31:0]                     stall_cycles
);

  typedef struct packed {
    logic              valid;
    logic              wen;
    logic              isload;
    logic [REG_AW-1:0] wreg;
  } entry_t;

  entry_t ent_q [STAGES][LANES];

  logic [2*LANES*REG_AW-1:0] src_all;
  logic                      found [2][LANES];
  logic                      early [2][LANES];
  logic [DATA_W-1:0]         pdata [2][LANES];

  assign src_all = {issue_srcB, issue_srcA};

  // Scan oldest to youngest so the last hit is the youngest producer.
  always_comb begin
    for (int op = 0; op < 2; op++) begin
      for (int ln = 0; ln < LANES; ln++) begin
        found[op][ln] = 1'b0;
        early[op][ln] = 1'b0;
        pdata[op][ln] = '0;
        for (int s = STAGES - 1; s >= 0; s--) begin
          for (int l = 0; l < LANES; l++) begin
            if (ent_q[s][l].valid && ent_q[s][l].wen &&
                src_all[(op*LANES+ln)*REG_AW +: REG_AW] != '0 &&
                ent_q[s][l].wreg ==
                src_all[(op*LANES+ln)*REG_AW +: REG_AW]) begin
              found[op][ln] = 1'b1;
              early[op][ln] = ent_q[s][l].isload && (s < LOAD_LAT);
              pdata[op][ln] =
                stage_data[(s*LANES+l)*DATA_W +: DATA_W];
            end
          end
        end
      end
    end
  end

  always_comb begin
    stall = 1'b0;
    for (int ln = 0; ln < LANES; ln++) begin
      for (int op = 0; op < 2; op++) begin
        if (issue_valid[ln] && found[op][ln] && early[op][ln])
          stall = 1'b1;
      end
    end
  end

  always_comb begin
    fwdA_hit  = '0;
    fwdB_hit  = '0;
    fwdA_data = '0;
    fwdB_data = '0;
    for (int ln = 0; ln < LANES; ln++) begin
      if (!stall && issue_valid[ln] && found[0][ln]) begin
        fwdA_hit[ln] = 1'b1;
        fwdA_data[ln*DATA_W +: DATA_W] = pdata[0][ln];
      end
      if (!stall && issue_valid[ln] && found[1][ln]) begin
        fwdB_hit[ln] = 1'b1;
        fwdB_data[ln*DATA_W +: DATA_W] = pdata[1][ln];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int s = 0; s < STAGES; s++)
        for (int l = 0; l < LANES; l++)
          ent_q[s][l] <= '0;
    end else if (!FREEZE) begin
      for (int s = 1; s < STAGES; s++)
        for (int l = 0; l < LANES; l++)
          ent_q[s][l] <= ent_q[s-1][l];
      for (int l = 0; l < LANES; l++) begin
        if (stall || FLUSH)
          ent_q[0][l] <= '0;
        else
          ent_q[0][l] <= '{
            valid:  issue_valid[l],
            wen:    issue_wen[l],
            isload: issue_isload[l],
            wreg:   issue_wreg[l*REG_AW +: REG_AW]
          };
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET)
      stall_cycles <= '0;
    else if (!FREEZE && stall && stall_cycles != 32'hFFFF_FFFF)
      stall_cycles <= stall_cycles + 32'd1;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_hazard_scoreboard;
  localparam int LANES  = 2;
  localparam int STAGES = 3;
  localparam int AW     = 5;
  localparam int DW     = 32;
  localparam int LL     = 1;

  logic CLK = 1'b0;
  logic RESET, FREEZE, FLUSH;
  logic [LANES-1:0] issue_valid, issue_wen, issue_isload;
  logic [LANES*AW-1:0] issue_wreg, issue_srcA, issue_srcB;
  logic [STAGES*LANES*DW-1:0] stage_data;
  logic stall;
  logic [LANES-1:0] fwdA_hit, fwdB_hit;
  logic [LANES*DW-1:0] fwdA_data, fwdB_data;
  logic [31:0] stall_cycles;

  hazard_scoreboard #(
    .LANES(LANES), .STAGES(STAGES), .REG_AW(AW),
    .DATA_W(DW), .LOAD_LAT(LL)
  ) dut (
    .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE), .FLUSH(FLUSH),
    .issue_valid(issue_valid), .issue_wen(issue_wen),
    .issue_isload(issue_isload), .issue_wreg(issue_wreg),
    .issue_srcA(issue_srcA), .issue_srcB(issue_srcB),
    .stage_data(stage_data), .stall(stall),
    .fwdA_hit(fwdA_hit), .fwdB_hit(fwdB_hit),
    .fwdA_data(fwdA_data), .fwdB_data(fwdB_data),
    .stall_cycles(stall_cycles)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [LANES-1:0]         v;
    logic [LANES-1:0]         w;
    logic [LANES-1:0]         ld;
    logic [LANES-1:0][AW-1:0] r;
  } bund_t;

  bund_t pipe[$];
  int unsigned m_cnt;
  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // pipe[0] is EXE; within a stage the higher lane is younger.
  task automatic lookup(input logic [AW-1:0] src, output bit hit,
                        output bit early, output logic [DW-1:0] d);
    hit = 0; early = 0; d = '0;
    if (src == 0) return;
    for (int s = 0; s < STAGES; s++)
      for (int l = LANES - 1; l >= 0; l--)
        if (pipe[s].v[l] && pipe[s].w[l] && pipe[s].r[l] == src) begin
          hit = 1;
          early = pipe[s].ld[l] && (s < LL);
          d = stage_data[(s*LANES+l)*DW +: DW];
          return;
        end
  endtask

  function automatic logic [AW-1:0] src_of(int op, int l);
    return op == 0 ? issue_srcA[l*AW +: AW] : issue_srcB[l*AW +: AW];
  endfunction

  task automatic model_stall(output bit st);
    bit h, e;
    logic [DW-1:0] d;
    st = 0;
    for (int l = 0; l < LANES; l++)
      for (int op = 0; op < 2; op++)
        if (issue_valid[l]) begin
          lookup(src_of(op, l), h, e, d);
          if (h && e) st = 1;
        end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      bit st, h, e;
      logic [DW-1:0] d;
      model_stall(st);
      chk("stall", {31'd0, stall}, {31'd0, st});
      chk("stall_cycles", stall_cycles, m_cnt);
      for (int l = 0; l < LANES; l++) begin
        for (int op = 0; op < 2; op++) begin
          lookup(src_of(op, l), h, e, d);
          h = h && issue_valid[l] && !st;
          if (!h) d = '0;
          if (op == 0) begin
            chk($sformatf("fwdA_hit[%0d]", l), {31'd0, fwdA_hit[l]}, {31'd0, h});
            chk($sformatf("fwdA_data[%0d]", l), fwdA_data[l*DW +: DW], d);
          end else begin
            chk($sformatf("fwdB_hit[%0d]", l), {31'd0, fwdB_hit[l]}, {31'd0, h});
            chk($sformatf("fwdB_data[%0d]", l), fwdB_data[l*DW +: DW], d);
          end
        end
      end
    end
  end

  always @(posedge CLK) begin
    bit st;
    bund_t nb;
    model_stall(st);
    if (RESET) begin
      for (int s = 0; s < STAGES; s++) pipe[s] = '0;
      m_cnt = 0;
    end else if (!FREEZE) begin
      if (st && m_cnt != 32'hFFFF_FFFF) m_cnt++;
      nb = '0;
      if (!st && !FLUSH) begin
        nb.v = issue_valid;
        nb.w = issue_wen;
        nb.ld = issue_isload;
        for (int l = 0; l < LANES; l++) nb.r[l] = issue_wreg[l*AW +: AW];
      end
      pipe.push_front(nb);
      void'(pipe.pop_back());
    end
  end

  task automatic to_pos(); @(posedge CLK); #1; endtask
  task automatic to_neg(); @(negedge CLK); #1; endtask

  task automatic idle();
    FREEZE = 0; FLUSH = 0;
    issue_valid = '0; issue_wen = '0; issue_isload = '0;
    issue_wreg = '0; issue_srcA = '0; issue_srcB = '0;
  endtask

  task automatic set_ent(int s, int l, logic [31:0] v);
    stage_data[(s*LANES+l)*DW +: DW] = v;
  endtask

  initial begin
    for (int s = 0; s < STAGES; s++) pipe.push_back('0);
    m_cnt = 0;
    RESET = 1; stage_data = '0;
    idle();
    to_pos(); to_pos();
    RESET = 0; chk_en = 1;
    to_neg();
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_hits", {28'd0, fwdA_hit, fwdB_hit}, 32'd0);
    chk("rst_cnt", stall_cycles, 32'd0);

    // ALU forward to lane 1
    to_pos();
    issue_valid = 2'b01; issue_wen = 2'b01; issue_wreg[0 +: AW] = 5'd5;
    to_pos();
    idle();
    issue_valid = 2'b10; issue_srcA[AW +: AW] = 5'd5;
    set_ent(0, 0, 32'h1234);
    to_neg();
    chk("alu_hit", {31'd0, fwdA_hit[1]}, 32'd1);
    chk("alu_data", fwdA_data[DW +: DW], 32'h1234);
    chk("alu_stall", {31'd0, stall}, 32'd0);

    // load-use: one stall cycle, then forward from stage 1
    to_pos();
    idle();
    issue_valid = 2'b01; issue_wen = 2'b01; issue_isload = 2'b01;
    issue_wreg[0 +: AW] = 5'd7;
    to_pos();
    idle();
    issue_valid = 2'b01; issue_srcA[0 +: AW] = 5'd7;
    set_ent(1, 0, 32'h7777);
    to_neg();
    chk("lu_stall", {31'd0, stall}, 32'd1);
    chk("lu_nohit", {31'd0, fwdA_hit[0]}, 32'd0);
    to_pos();
    to_neg();
    chk("lu_clear", {31'd0, stall}, 32'd0);
    chk("lu_cnt", stall_cycles, 32'd1);
    chk("lu_fwd", fwdA_data[0 +: DW], 32'h7777);

    // youngest producer wins
    to_pos();
    idle();
    issue_valid = 2'b01; issue_wen = 2'b01; issue_wreg[0 +: AW] = 5'd3;
    to_pos();
    issue_valid = 2'b11; issue_wen = 2'b11; issue_wreg = {5'd3, 5'd3};
    to_pos();
    idle();
    issue_valid = 2'b01; issue_srcB[0 +: AW] = 5'd3;
    set_ent(0, 0, 32'hA); set_ent(0, 1, 32'hB); set_ent(1, 0, 32'hC);
    to_neg();
    chk("young_hit", {31'd0, fwdB_hit[0]}, 32'd1);
    chk("young_data", fwdB_data[0 +: DW], 32'hB);

    // r0 never forwards
    to_pos();
    idle();
    issue_valid = 2'b01; issue_wen = 2'b01;
    to_pos();
    idle();
    issue_valid = 2'b01;
    stage_data = {6{32'h5A5A}};
    to_neg();
    chk("r0_hits", {28'd0, fwdA_hit, fwdB_hit}, 32'd0);
    chk("r0_stall", {31'd0, stall}, 32'd0);

    // load-use held by FREEZE
    to_pos();
    idle();
    issue_valid = 2'b10; issue_wen = 2'b10; issue_isload = 2'b10;
    issue_wreg[AW +: AW] = 5'd9;
    to_pos();
    idle();
    issue_valid = 2'b01; issue_srcA[0 +: AW] = 5'd9; FREEZE = 1;
    for (int i = 0; i < 4; i++) begin
      to_neg();
      chk("frz_stall", {31'd0, stall}, 32'd1);
      chk("frz_cnt", stall_cycles, 32'd1);
      to_pos();
    end
    FREEZE = 0;
    to_neg();
    chk("unfrz_stall", {31'd0, stall}, 32'd1);
    to_pos();
    to_neg();
    chk("unfrz_clear", {31'd0, stall}, 32'd0);
    chk("unfrz_cnt", stall_cycles, 32'd2);

    // FLUSH kills the ID bundle
    to_pos();
    idle();
    issue_valid = 2'b01; issue_wen = 2'b01; issue_wreg[0 +: AW] = 5'd11;
    FLUSH = 1;
    to_pos();
    idle();
    issue_valid = 2'b01; issue_srcA[0 +: AW] = 5'd11;
    to_neg();
    chk("flush_hit", {31'd0, fwdA_hit[0]}, 32'd0);

    // RESET mid-stall
    to_pos();
    idle();
    issue_valid = 2'b01; issue_wen = 2'b01; issue_isload = 2'b01;
    issue_wreg[0 +: AW] = 5'd12;
    to_pos();
    idle();
    issue_valid = 2'b01; issue_srcB[0 +: AW] = 5'd12;
    to_neg();
    chk("rs_stall", {31'd0, stall}, 32'd1);
    RESET = 1;
    to_pos();
    RESET = 0;
    to_neg();
    chk("rs_clear", {31'd0, stall}, 32'd0);
    chk("rs_cnt", stall_cycles, 32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      to_pos();
      issue_valid = LANES'($urandom);
      issue_wen = LANES'($urandom);
      for (int l = 0; l < LANES; l++) begin
        issue_isload[l] = ($urandom_range(0, 3) == 0);
        issue_wreg[l*AW +: AW] = AW'($urandom_range(0, 7));
        issue_srcA[l*AW +: AW] = AW'($urandom_range(0, 7));
        issue_srcB[l*AW +: AW] = AW'($urandom_range(0, 7));
      end
      for (int k = 0; k < STAGES * LANES; k++)
        stage_data[k*DW +: DW] = $urandom;
      FREEZE = ($urandom_range(0, 9) == 0);
      FLUSH = ($urandom_range(0, 9) == 0);
      RESET = ($urandom_range(0, 99) == 0);
    end
    to_pos();
    RESET = 0; idle();
    to_neg();
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter LANES, default 2, number of instructions issued per cycle; lane 0 is oldest in program order.
REQ-002 Parameter STAGES, default 3, number of tracked stages after ID; stage 0 is EXE, stage STAGES-1 is WB.
REQ-003 Parameter REG_AW, default 5, register-address width.
REQ-004 Parameter DATA_W, default 32, datapath width.
REQ-005 Parameter LOAD_LAT, default 1, first stage index at which load data is valid; range 0..STAGES-1.
REQ-006 CLK  in  1  sole clock; all state updates on its rising edge.
REQ-007 RESET  in  1  synchronous, active-high reset.
REQ-008 FREEZE  in  1  global hold, for a memory miss.
REQ-009 FLUSH  in  1  taken branch; kills the bundle currently in ID.
REQ-010 issue_valid  in  LANES  per-lane instruction present in ID.
REQ-011 issue_wen  in  LANES  per-lane writes a register.
REQ-012 issue_isload  in  LANES  per-lane is a load.
REQ-013 issue_wreg  in  LANES*REG_AW  per-lane destination register.
REQ-014 issue_srcA and issue_srcB  in  LANES*REG_AW each  per-lane source registers.
REQ-015 stage_data  in  STAGES*LANES*DATA_W  result of each stage/lane entry, index stage*LANES+lane.
REQ-016 stall  out  1  load-use interlock; the ID bundle is not accepted.
REQ-017 fwdA_hit and fwdB_hit  out  LANES each  a forwarded operand is supplied.
REQ-018 fwdA_data and fwdB_data  out  LANES*DATA_W each  forwarded operand values.
REQ-019 stall_cycles  out  32  saturating stall-cycle counter.

Function
REQ-020 Each stage/lane entry holds valid, wen, isload and wreg.
REQ-021 On a clock with FREEZE=0, entry s moves to s+1 and entry STAGES-1 is discarded.
REQ-022 On a clock with FREEZE=0, stage 0 loads the ID bundle, masked by issue_valid, only when stall=0 and FLUSH=0; otherwise stage 0 loads a bubble (all valid=0).
REQ-023 On a clock with FREEZE=1, all entries and stall_cycles hold; FLUSH is ignored, and upstream holds FLUSH until FREEZE falls.
REQ-024 A producer matches a source when valid=1, wen=1, wreg equals the source, and the source is non-zero; register 0 never matches.
REQ-025 The producer for a source is the youngest match: lowest stage index first, then highest lane within that stage.
REQ-026 Stall condition: the producer of any valid lane's source is a load in stage s < LOAD_LAT.
REQ-027 When the stall condition holds, stall=1; all fwd*_hit=0 for that cycle.
REQ-028 Otherwise fwd*_hit=1 and fwd*_data=stage_data of the producer entry.
REQ-029 With no producer, or an invalid lane, fwd*_hit=0 and fwd*_data=0.
REQ-030 stall, fwd*_hit and fwd*_data are combinational from the current inputs and registered entries; no added latency.
REQ-031 stall is computed regardless of FREEZE.
REQ-032 RAW dependences within one ID bundle are not detected; ID issue logic guarantees their absence.
REQ-033 stall_cycles increments by 1 on each clock with stall=1 and FREEZE=0, and saturates at 0xFFFFFFFF.
REQ-034 FLUSH=1 and stall=1 together produce one bubble; stall_cycles still counts that cycle.

Reset
REQ-035 On a clock with RESET=1, all entry valid bits clear and stall_cycles=0; RESET overrides FREEZE and FLUSH.
REQ-036 After reset, with no valid entries: stall=0, all fwd*_hit=0, all fwd*_data=0.
REQ-037 Reset asserted mid-stall clears the interlock on the following cycle.

Verification
REQ-038 Setup: LANES=2, STAGES=3, LOAD_LAT=1. ALU lane0 writes r5; next bundle lane1 reads srcA=r5; stage_data[0]=0x1234 -> fwdA_hit[1]=1, fwdA_data=0x1234, stall=0.
REQ-039 Load r7, then next bundle lane0 reads r7 -> stall=1 for exactly 1 cycle; stall_cycles=1; after the stall, fwd from stage 1 data.
REQ-040 Stage0 lane0 writes r3=0xA, stage0 lane1 writes r3=0xB, stage1 writes r3=0xC -> a read of r3 forwards 0xB.
REQ-041 A source of r0 with a producer writing r0 -> fwd*_hit=0, stall=0.
REQ-042 Load-use stall with FREEZE=1 held 4 cycles -> entries unchanged, stall=1 throughout, stall_cycles unchanged; stall clears 1 cycle after FREEZE falls.
REQ-043 FLUSH=1 with a valid bundle -> stage 0 empty next cycle; a later read of its wreg gives hit=0; RESET mid-stall -> stall=0 and stall_cycles=0 next cycle.
